// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Front-end stage of the 8-bit accumulator CPU. Reads each two-byte
// instruction (opcode byte, then operand byte) from the shared synchronous
// RAM. It then presents the instruction to decode/execute through a
// valid/ready handshake. The unit owns the PC and accepts redirects from
// execute.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   run          fetch enable; low blocks the start of a new instruction
//   mem_req      read request to the RAM arbiter
//   mem_gnt      arbiter grant; RAM captures mem_addr on req && gnt edges
//   mem_addr     read address, driven from the PC
//   mem_oe       read output enable, identical to mem_req
//   mem_rdata    RAM read data, valid the cycle after a granting edge
//   ir_valid     instruction available
//   ir_ready     execute accepts the instruction
//   ir_a         opcode byte
//   ir_b         operand/address byte
//   ir_pc        address of the opcode byte of the presented instruction
//   redirect     load redirect_pc and drop any in-flight/held instruction
//   redirect_pc  redirect target
//   pc_out       current fetch PC (next byte to be fetched)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_oe,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    output logic [DATA_WIDTH-1:0] ir_a,
    output logic [DATA_WIDTH-1:0] ir_b,
    output logic [ADDR_WIDTH-1:0] ir_pc,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] pc_out
);

    typedef enum logic [2:0] {
        FETCH_A = 3'd0,
        CAP_A   = 3'd1,
        FETCH_B = 3'd2,
        CAP_B   = 3'd3,
        HOLD    = 3'd4
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] pc;

    // State register. Reset always returns to FETCH_A, even from a mid-fetch
    // state with a grant outstanding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH_A;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and memory request decode. The opcode fetch only
    // starts while run is high. Once the opcode is in, the operand fetch
    // ignores run, so an instruction is never left half-fetched. A redirect
    // abandons whatever is in progress and restarts at FETCH_A. mem_req is
    // also held low while rst_n is low, so no read goes out during reset.
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        case (state)
            FETCH_A: begin
                mem_req = run;
                if (run && mem_gnt) next_state = CAP_A;
            end
            CAP_A:   next_state = FETCH_B;
            FETCH_B: begin
                mem_req = 1'b1;
                if (mem_gnt) next_state = CAP_B;
            end
            CAP_B:   next_state = HOLD;
            HOLD: begin
                if (ir_ready) next_state = FETCH_A;
            end
            default: next_state = FETCH_A;
        endcase
        if (redirect) next_state = FETCH_A;
        mem_req = mem_req && rst_n;
    end

    assign mem_oe   = mem_req;
    assign mem_addr = pc;
    assign pc_out   = pc;

    // Datapath registers. The PC advances as each byte is captured, and wraps
    // modulo 2^ADDR_WIDTH. A redirect in HOLD with ir_ready high still counts
    // as a consumed instruction, because clearing ir_valid is what the
    // handshake would have done anyway. Read data that arrives after a
    // redirect is never captured, because the FSM has already left CAP_A and
    // CAP_B.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            ir_valid <= 1'b0;
            ir_a     <= '0;
            ir_b     <= '0;
            ir_pc    <= '0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            ir_valid <= 1'b0;
        end else begin
            case (state)
                FETCH_A: begin
                    if (run && mem_gnt) ir_pc <= pc;
                end
                CAP_A: begin
                    ir_a <= mem_rdata;
                    pc   <= pc + ADDR_WIDTH'(1);
                end
                CAP_B: begin
                    ir_b     <= mem_rdata;
                    pc       <= pc + ADDR_WIDTH'(1);
                    ir_valid <= 1'b1;
                end
                HOLD: begin
                    if (ir_valid && ir_ready) ir_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. A behavioural 256x8 synchronous
// RAM feeds the DUT. Directed phases exercise reset, latency, backpressure,
// arbitration, redirect, wrap and reset in mid-fetch. A randomized phase then
// compares every consumed instruction against a reference that walks the
// program as a flat byte array: two bytes per instruction, restarting at the
// redirect target whenever a redirect occurs.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       mem_req;
    logic       mem_gnt;
    logic [7:0] mem_addr;
    logic       mem_oe;
    logic [7:0] mem_rdata;
    logic       ir_valid;
    logic       ir_ready;
    logic [7:0] ir_a;
    logic [7:0] ir_b;
    logic [7:0] ir_pc;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic [7:0] pc_out;

    logic [7:0] ram [256];

    int check_count = 0;
    int error_count = 0;

    instr_fetch_unit #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .RESET_PC  (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_addr   (mem_addr),
        .mem_oe     (mem_oe),
        .mem_rdata  (mem_rdata),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ir_a       (ir_a),
        .ir_b       (ir_b),
        .ir_pc      (ir_pc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .pc_out     (pc_out)
    );

    // 10 time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM. The address is captured on a granted edge, and the
    // data is held for the following cycle.
    always @(posedge clk) begin
        if (mem_req && mem_gnt) mem_rdata <= ram[mem_addr];
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive all control inputs together, away from the clock edge.
    task automatic applyStimulus(input logic r, input logic g, input logic rdy,
                                 input logic rd, input logic [7:0] rpc);
        run         = r;
        mem_gnt     = g;
        ir_ready    = rdy;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    // Advance one clock; sampling and driving happen 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] model_pc;
        logic [7:0] next_byte;
        logic       handshake;
        int         hs_count;

        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
        ram[8'h00] = 8'h10;  ram[8'h01] = 8'h30;
        ram[8'h02] = 8'hA1;  ram[8'h03] = 8'hB2;
        ram[8'h0A] = 8'h5C;  ram[8'h0B] = 8'h7D;
        ram[8'h16] = 8'h81;  ram[8'h17] = 8'h00;
        ram[8'hFF] = 8'h90;
        mem_rdata = 8'h00;

        // Reset state.
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("rst_valid", 32'(ir_valid), 32'd0);
        checkOutput("rst_pc", 32'(pc_out), 32'h00);
        checkOutput("rst_req", 32'(mem_req), 32'd0);
        checkOutput("rst_ir_a", 32'(ir_a), 32'h00);
        rst_n = 1'b1;

        // Basic fetch: ir_valid rises on the 4th edge after reset release.
        tick(); tick(); tick();
        checkOutput("lat_not_yet", 32'(ir_valid), 32'd0);
        tick();
        checkOutput("basic_valid", 32'(ir_valid), 32'd1);
        checkOutput("basic_ir_a", 32'(ir_a), 32'h10);
        checkOutput("basic_ir_b", 32'(ir_b), 32'h30);
        checkOutput("basic_ir_pc", 32'(ir_pc), 32'h00);
        tick();
        checkOutput("basic_hs_valid", 32'(ir_valid), 32'd0);
        checkOutput("basic_pc_out", 32'(pc_out), 32'h02);
        checkOutput("basic_addr", 32'(mem_addr), 32'h02);
        checkOutput("basic_req", 32'(mem_req), 32'd1);

        // Backpressure: the instruction at 02 must be held while ir_ready is low.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        tick(); tick(); tick(); tick();
        for (int i = 0; i < 6; i++) begin
            checkOutput("bp_valid", 32'(ir_valid), 32'd1);
            checkOutput("bp_req", 32'(mem_req), 32'd0);
            checkOutput("bp_ir_a", 32'(ir_a), 32'hA1);
            checkOutput("bp_ir_b", 32'(ir_b), 32'hB2);
            checkOutput("bp_ir_pc", 32'(ir_pc), 32'h02);
            if (i < 5) tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        tick();
        checkOutput("bp_release_valid", 32'(ir_valid), 32'd0);
        checkOutput("bp_next_addr", 32'(mem_addr), 32'h04);

        // Arbitration: the grant is withheld for 3 cycles in FETCH_B at 17.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h16);
        tick();
        checkOutput("arb_redir_pc", 32'(pc_out), 32'h16);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        tick(); tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("arb_hold_req", 32'(mem_req), 32'd1);
            checkOutput("arb_hold_addr", 32'(mem_addr), 32'h17);
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        checkOutput("arb_capb_valid", 32'(ir_valid), 32'd0);
        ir_ready = 1'b0;
        tick();
        checkOutput("arb_valid", 32'(ir_valid), 32'd1);
        checkOutput("arb_ir_a", 32'(ir_a), 32'h81);
        checkOutput("arb_ir_b", 32'(ir_b), 32'h00);
        checkOutput("arb_ir_pc", 32'(ir_pc), 32'h16);

        // Redirect (a): asserted while the unit is in CAP_A of the instruction at 18.
        ir_ready = 1'b1;
        tick();
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h0A);
        tick();
        checkOutput("rda_pc", 32'(pc_out), 32'h0A);
        checkOutput("rda_valid", 32'(ir_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rda_no_old", 32'(ir_valid), 32'd0);
        end
        tick();
        checkOutput("rda_new_valid", 32'(ir_valid), 32'd1);
        checkOutput("rda_ir_pc", 32'(ir_pc), 32'h0A);
        checkOutput("rda_ir_a", 32'(ir_a), 32'h5C);
        checkOutput("rda_ir_b", 32'(ir_b), 32'h7D);

        // Redirect (b): asserted in HOLD together with ir_ready.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h0A);
        tick();
        checkOutput("rdb_valid", 32'(ir_valid), 32'd0);
        checkOutput("rdb_pc", 32'(pc_out), 32'h0A);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        tick(); tick(); tick(); tick();
        checkOutput("rdb_new_valid", 32'(ir_valid), 32'd1);
        checkOutput("rdb_ir_pc", 32'(ir_pc), 32'h0A);

        // Wrap: the opcode is at FF and the operand at 00.
        ram[8'h00] = 8'h06;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        tick(); tick(); tick(); tick();
        checkOutput("wrap_valid", 32'(ir_valid), 32'd1);
        checkOutput("wrap_ir_a", 32'(ir_a), 32'h90);
        checkOutput("wrap_ir_b", 32'(ir_b), 32'h06);
        checkOutput("wrap_ir_pc", 32'(ir_pc), 32'hFF);
        checkOutput("wrap_pc_out", 32'(pc_out), 32'h01);

        // Reset in mid-fetch: rst_n goes low while the unit is in CAP_B.
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        checkOutput("mid_rst_valid", 32'(ir_valid), 32'd0);
        checkOutput("mid_rst_pc", 32'(pc_out), 32'h00);
        checkOutput("mid_rst_req", 32'(mem_req), 32'd0);
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        checkOutput("mid_rst_next_valid", 32'(ir_valid), 32'd1);
        checkOutput("mid_rst_next_pc", 32'(ir_pc), 32'h00);
        checkOutput("mid_rst_next_a", 32'(ir_a), 32'h06);
        checkOutput("mid_rst_next_b", 32'(ir_b), 32'h30);

        // With run low, no new opcode fetch is started after the handshake.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        tick();
        checkOutput("run_low_req", 32'(mem_req), 32'd0);
        tick(); tick();
        checkOutput("run_low_pc", 32'(pc_out), 32'h02);
        checkOutput("run_low_valid", 32'(ir_valid), 32'd0);

        // Randomized phase against the flat byte-stream reference.
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_pc = 8'h00;
        hs_count = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            applyStimulus(($urandom % 8) != 0, ($urandom % 4) != 0,
                          ($urandom % 3) != 0, ($urandom % 25) == 0,
                          8'($urandom));
            checkOutput("rand_oe", 32'(mem_oe), 32'(mem_req));
            if (ir_valid) checkOutput("rand_hold_req", 32'(mem_req), 32'd0);
            handshake = ir_valid && ir_ready;
            if (handshake) begin
                next_byte = model_pc + 8'd1;
                checkOutput("rand_ir_pc", 32'(ir_pc), 32'(model_pc));
                checkOutput("rand_ir_a", 32'(ir_a), 32'(ram[model_pc]));
                checkOutput("rand_ir_b", 32'(ir_b), 32'(ram[next_byte]));
                model_pc = model_pc + 8'd2;
                hs_count++;
            end
            if (redirect) model_pc = redirect_pc;
            tick();
        end
        checkOutput("rand_progress", 32'(hs_count >= 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
